// File: rtl/vga_demo_pkg.sv
// Shared constants and state encoding for the VGA text demo datapath.
package vga_demo_pkg;

    localparam int SCREEN_W = 640;
    localparam int SCREEN_H = 480;
    localparam int COLOR_W  = 3;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_MOVE  = 2'd1,
        ST_PAUSE = 2'd2
    } motion_state_t;

endpackage

// File: rtl/bounce_axis.sv
// One axis of the bouncing object: clamps at 0 and LIMIT and reflects direction.
module bounce_axis
    import vga_demo_pkg::*;
#(
    parameter int LIMIT = 80,
    parameter int START = 10
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       advance,
    input  logic [2:0] step,
    output logic [9:0] pos,
    output logic       dir,
    output logic       hit
);

    logic [10:0] sum_up;
    logic        at_high;
    logic        at_low;

    // The sum is one bit wider so a step past LIMIT is seen before it can wrap.
    assign sum_up  = {1'b0, pos} + {8'd0, step};
    assign at_high = (sum_up >= 11'(LIMIT));
    assign at_low  = (pos <= {7'd0, step});
    assign hit     = advance && (dir ? at_low : at_high);

    // Move one step per advance strobe, landing exactly on the edge and reversing when it is reached.
    always_ff @(posedge clk) begin
        if (reset) begin
            pos <= 10'(START);
            dir <= 1'b0;
        end else if (advance) begin
            if (!dir) begin
                if (at_high) begin
                    pos <= 10'(LIMIT);
                    dir <= 1'b1;
                end else begin
                    pos <= sum_up[9:0];
                end
            end else begin
                if (at_low) begin
                    pos <= 10'd0;
                    dir <= 1'b0;
                end else begin
                    pos <= pos - {7'd0, step};
                end
            end
        end
    end

endmodule

// File: rtl/bounce_motion_controller.sv
// Frame-rate scheduler for the bouncing banner: run/hold FSM, post-bounce dwell and colour stepping.
module bounce_motion_controller #(
    parameter int SCREEN_W     = vga_demo_pkg::SCREEN_W,
    parameter int SCREEN_H     = vga_demo_pkg::SCREEN_H,
    parameter int OBJ_W        = 560,
    parameter int OBJ_H        = 32,
    parameter int START_X      = 10,
    parameter int START_Y      = 10,
    parameter int PAUSE_FRAMES = 8,
    parameter int COLOR_W      = vga_demo_pkg::COLOR_W
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               frame_tick,
    input  logic               run_en,
    input  logic [1:0]         speed,
    output logic [9:0]         pos_x,
    output logic [9:0]         pos_y,
    output logic [COLOR_W-1:0] color_index,
    output logic               bounce_pulse,
    output logic [1:0]         state_o
);

    import vga_demo_pkg::*;

    localparam int MAX_X = SCREEN_W - OBJ_W;
    localparam int MAX_Y = SCREEN_H - OBJ_H;
    localparam int CNT_W = (PAUSE_FRAMES > 1) ? $clog2(PAUSE_FRAMES + 1) : 1;

    motion_state_t    state;
    motion_state_t    state_next;
    logic [CNT_W-1:0] pause_cnt;
    logic [CNT_W-1:0] pause_cnt_next;
    logic [2:0]       step;
    logic             advance;
    logic             hit_x;
    logic             hit_y;
    logic             any_hit;
    logic             dir_x;
    logic             dir_y;
    logic             unused_dirs;

    // A run_en drop suppresses movement even when it lands on a frame tick.
    assign step        = {1'b0, speed} + 3'd1;
    assign advance     = (state == ST_MOVE) && frame_tick && run_en;
    assign any_hit     = hit_x || hit_y;
    assign state_o     = state;
    assign unused_dirs = dir_x ^ dir_y;

    bounce_axis #(.LIMIT(MAX_X), .START(START_X)) u_axis_x (
        .clk     (clk),
        .reset   (reset),
        .advance (advance),
        .step    (step),
        .pos     (pos_x),
        .dir     (dir_x),
        .hit     (hit_x)
    );

    bounce_axis #(.LIMIT(MAX_Y), .START(START_Y)) u_axis_y (
        .clk     (clk),
        .reset   (reset),
        .advance (advance),
        .step    (step),
        .pos     (pos_y),
        .dir     (dir_y),
        .hit     (hit_y)
    );

    // Next-state logic: run_en low forces IDLE, otherwise the FSM only moves on frame ticks.
    always_comb begin
        state_next     = state;
        pause_cnt_next = pause_cnt;
        if (!run_en) begin
            state_next     = ST_IDLE;
            pause_cnt_next = '0;
        end else if (frame_tick) begin
            case (state)
                ST_IDLE: begin
                    state_next = ST_MOVE;
                end
                ST_MOVE: begin
                    if (any_hit && (PAUSE_FRAMES > 0)) begin
                        state_next     = ST_PAUSE;
                        pause_cnt_next = CNT_W'(PAUSE_FRAMES);
                    end
                end
                ST_PAUSE: begin
                    if (pause_cnt <= CNT_W'(1)) begin
                        state_next     = ST_MOVE;
                        pause_cnt_next = '0;
                    end else begin
                        pause_cnt_next = pause_cnt - CNT_W'(1);
                    end
                end
                default: begin
                    state_next = ST_IDLE;
                end
            endcase
        end
    end

    // Register FSM state, dwell counter, colour and the one-cycle bounce pulse.
    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= ST_IDLE;
            pause_cnt    <= '0;
            color_index  <= COLOR_W'(1);
            bounce_pulse <= 1'b0;
        end else begin
            state        <= state_next;
            pause_cnt    <= pause_cnt_next;
            bounce_pulse <= any_hit;
            if (any_hit) begin
                color_index <= color_index + COLOR_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_bounce_motion_controller.sv
// Scoreboard bench for bounce_motion_controller: a behavioural model predicts each cycle's outputs.
module tb_bounce_motion_controller;

    typedef struct {
        int x;
        int y;
        bit dx;
        bit dy;
        int color;
        bit pulse;
        int st;
        int cnt;
    } model_t;

    logic       clk = 1'b0;
    logic       reset = 1'b0, frame_tick = 1'b0, run_en = 1'b0;
    logic [1:0] speed = 2'd0;
    logic [9:0] pos_x, pos_y;
    logic [2:0] color_index;
    logic       bounce_pulse;
    logic [1:0] state_o;

    logic       reset2 = 1'b0, frame_tick2 = 1'b0, run_en2 = 1'b0;
    logic [1:0] speed2 = 2'd0;
    logic [9:0] pos_x2, pos_y2;
    logic [2:0] color_index2;
    logic       bounce_pulse2;
    logic [1:0] state_o2;

    bit         g_rst1, g_tk1, g_run1, g_rst2, g_tk2, g_run2;
    int         g_sp1, g_sp2;
    model_t     m1, m2;
    logic [25:0] sb1[$];
    logic [25:0] sb2[$];
    int         checks = 0;
    int         failures = 0;

    always #5 clk = ~clk;

    bounce_motion_controller dut (
        .clk(clk), .reset(reset), .frame_tick(frame_tick), .run_en(run_en), .speed(speed),
        .pos_x(pos_x), .pos_y(pos_y), .color_index(color_index),
        .bounce_pulse(bounce_pulse), .state_o(state_o)
    );

    bounce_motion_controller #(.START_X(79), .START_Y(447)) dut2 (
        .clk(clk), .reset(reset2), .frame_tick(frame_tick2), .run_en(run_en2), .speed(speed2),
        .pos_x(pos_x2), .pos_y(pos_y2), .color_index(color_index2),
        .bounce_pulse(bounce_pulse2), .state_o(state_o2)
    );

    function automatic model_t model_step(model_t m, bit rst, bit run, bit tk, int spd, int sx, int sy);
        model_t n;
        int     step;
        bit     hit;
        n = m;
        n.pulse = 1'b0;
        if (rst) begin
            n.x = sx; n.y = sy; n.dx = 0; n.dy = 0; n.color = 1; n.st = 0; n.cnt = 0;
            return n;
        end
        if (!run) begin
            n.st = 0; n.cnt = 0;
            return n;
        end
        if (!tk) return n;
        step = spd + 1;
        hit = 1'b0;
        case (m.st)
            0: n.st = 1;
            1: begin
                if (!m.dx) begin
                    if (m.x + step >= 80) begin n.x = 80; n.dx = 1; hit = 1; end
                    else n.x = m.x + step;
                end else begin
                    if (m.x <= step) begin n.x = 0; n.dx = 0; hit = 1; end
                    else n.x = m.x - step;
                end
                if (!m.dy) begin
                    if (m.y + step >= 448) begin n.y = 448; n.dy = 1; hit = 1; end
                    else n.y = m.y + step;
                end else begin
                    if (m.y <= step) begin n.y = 0; n.dy = 0; hit = 1; end
                    else n.y = m.y - step;
                end
                if (hit) begin
                    n.color = (m.color + 1) % 8; n.pulse = 1; n.st = 2; n.cnt = 8;
                end
            end
            default: begin
                n.cnt = m.cnt - 1;
                if (n.cnt == 0) n.st = 1;
            end
        endcase
        return n;
    endfunction

    function automatic logic [25:0] pack(model_t m);
        return {10'(m.x), 10'(m.y), 3'(m.color), m.pulse, 2'(m.st)};
    endfunction

    function automatic logic [25:0] obs1();
        return {pos_x, pos_y, color_index, bounce_pulse, state_o};
    endfunction

    function automatic logic [25:0] obs2();
        return {pos_x2, pos_y2, color_index2, bounce_pulse2, state_o2};
    endfunction

    // Drive one clock of stimulus to both DUTs, queue the model's prediction, sample #1 after the edge.
    task automatic cycle();
        @(negedge clk);
        reset = g_rst1; frame_tick = g_tk1; run_en = g_run1; speed = 2'(g_sp1);
        reset2 = g_rst2; frame_tick2 = g_tk2; run_en2 = g_run2; speed2 = 2'(g_sp2);
        m1 = model_step(m1, g_rst1, g_run1, g_tk1, g_sp1, 10, 10);
        m2 = model_step(m2, g_rst2, g_run2, g_tk2, g_sp2, 79, 447);
        sb1.push_back(pack(m1));
        sb2.push_back(pack(m2));
        g_rst1 = 0; g_tk1 = 0; g_rst2 = 0; g_tk2 = 0;
        @(posedge clk);
        #1;
    endtask

    // Drive frames on the main DUT; quiet cycles carry speed 3 to show speed is only sampled on ticks.
    task automatic frames(input int n, input int spd, input string tag);
        logic [25:0] want, got;
        for (int i = 0; i < n; i++) begin
            for (int c = 0; c < 2; c++) begin
                g_tk1 = (c == 0);
                g_sp1 = (c == 0) ? spd : 3;
                cycle();
                want = sb1.pop_front();
                got = obs1();
                checks++;
                if (got !== want) begin
                    failures++;
                    $display("[TB] FAIL %s frame%0d cyc%0d: got %h want %h", tag, i, c, got, want);
                end
            end
        end
    endtask

    task automatic test_reset();
        logic [25:0] want, got;
        g_rst1 = 1; g_rst2 = 1; g_run1 = 0; g_run2 = 0;
        cycle();
        want = sb1.pop_front();
        got = obs1();
        checks++;
        if (got !== want) begin failures++; $display("[TB] FAIL reset: got %h want %h", got, want); end
        checks++;
        if (got !== {10'd10, 10'd10, 3'd1, 1'b0, 2'd0}) begin
            failures++; $display("[TB] FAIL reset_const: got %h want %h", got, {10'd10, 10'd10, 3'd1, 1'b0, 2'd0});
        end
        frames(2, 0, "idle_hold");
        checks++;
        if (obs1() !== {10'd10, 10'd10, 3'd1, 1'b0, 2'd0}) begin
            failures++; $display("[TB] FAIL idle_const: got %h want %h", obs1(), {10'd10, 10'd10, 3'd1, 1'b0, 2'd0});
        end
    endtask

    task automatic test_start_move();
        g_run1 = 1;
        frames(1, 0, "start_t1");
        checks++;
        if ({pos_x, pos_y, state_o} !== {10'd10, 10'd10, 2'd1}) begin
            failures++; $display("[TB] FAIL start_t1_const: got %h want %h", {pos_x, pos_y, state_o}, {10'd10, 10'd10, 2'd1});
        end
        frames(2, 0, "start_t23");
        checks++;
        if ({pos_x, pos_y} !== {10'd12, 10'd12}) begin
            failures++; $display("[TB] FAIL start_t3_const: got %h want %h", {pos_x, pos_y}, {10'd12, 10'd12});
        end
    endtask

    task automatic test_x_bounce();
        frames(68, 0, "x_bounce");
        checks++;
        if ({pos_x, color_index, state_o} !== {10'd80, 3'd2, 2'd2}) begin
            failures++; $display("[TB] FAIL x_bounce_const: got %h want %h", {pos_x, color_index, state_o}, {10'd80, 3'd2, 2'd2});
        end
        frames(8, 0, "pause");
        checks++;
        if (state_o !== 2'd1) begin failures++; $display("[TB] FAIL pause_end: got %0d want 1", state_o); end
        frames(1, 0, "resume");
        checks++;
        if (pos_x !== 10'd79) begin failures++; $display("[TB] FAIL resume_x: got %0d want 79", pos_x); end
    endtask

    task automatic test_clamp_low();
        frames(76, 0, "down");
        frames(1, 3, "clamp_low");
        checks++;
        if ({pos_x, color_index, state_o} !== {10'd0, 3'd3, 2'd2}) begin
            failures++; $display("[TB] FAIL clamp_low_const: got %h want %h", {pos_x, color_index, state_o}, {10'd0, 3'd3, 2'd2});
        end
        frames(9, 0, "low_resume");
        checks++;
        if (pos_x !== 10'd1) begin failures++; $display("[TB] FAIL low_dir: got %0d want 1", pos_x); end
    endtask

    task automatic test_clamp_high();
        frames(77, 0, "up");
        frames(1, 3, "clamp_high");
        checks++;
        if ({pos_x, color_index, state_o} !== {10'd80, 3'd4, 2'd2}) begin
            failures++; $display("[TB] FAIL clamp_high_const: got %h want %h", {pos_x, color_index, state_o}, {10'd80, 3'd4, 2'd2});
        end
    endtask

    task automatic test_reset_mid_pause();
        logic [25:0] want, got;
        frames(3, 0, "pause_part");
        g_rst1 = 1;
        cycle();
        want = sb1.pop_front();
        got = obs1();
        checks++;
        if (got !== want) begin failures++; $display("[TB] FAIL mid_pause_reset: got %h want %h", got, want); end
        checks++;
        if (got !== {10'd10, 10'd10, 3'd1, 1'b0, 2'd0}) begin
            failures++; $display("[TB] FAIL mid_pause_const: got %h want %h", got, {10'd10, 10'd10, 3'd1, 1'b0, 2'd0});
        end
    endtask

    task automatic test_run_drop();
        logic [25:0] want, got;
        frames(2, 0, "drop_setup");
        g_run1 = 0; g_tk1 = 1; g_sp1 = 0;
        cycle();
        want = sb1.pop_front();
        got = obs1();
        checks++;
        if (got !== want) begin failures++; $display("[TB] FAIL drop_on_tick: got %h want %h", got, want); end
        checks++;
        if ({pos_x, pos_y, state_o} !== {10'd11, 10'd11, 2'd0}) begin
            failures++; $display("[TB] FAIL drop_const: got %h want %h", {pos_x, pos_y, state_o}, {10'd11, 10'd11, 2'd0});
        end
        g_run1 = 1;
        frames(2, 0, "drop_rerun");
        g_run1 = 0;
        cycle();
        want = sb1.pop_front();
        got = obs1();
        checks++;
        if (got !== want) begin failures++; $display("[TB] FAIL drop_quiet: got %h want %h", got, want); end
    endtask

    task automatic test_dual_hit();
        logic [25:0] want, got;
        sb2.delete();
        g_rst2 = 1;
        cycle();
        void'(sb2.pop_front());
        g_run2 = 1;
        for (int i = 0; i < 6; i++) begin
            g_tk2 = (i % 2 == 0);
            g_sp2 = 0;
            cycle();
            want = sb2.pop_front();
            got = obs2();
            checks++;
            if (got !== want) begin failures++; $display("[TB] FAIL dual cyc%0d: got %h want %h", i, got, want); end
            if (i == 2) begin
                checks++;
                if (got !== {10'd80, 10'd448, 3'd2, 1'b1, 2'd2}) begin
                    failures++; $display("[TB] FAIL dual_const: got %h want %h", got, {10'd80, 10'd448, 3'd2, 1'b1, 2'd2});
                end
            end
        end
        sb1.delete();
    endtask

    initial begin
        $display("[TB] starting bounce_motion_controller bench");
        test_reset();
        test_start_move();
        test_x_bounce();
        test_clamp_low();
        test_clamp_high();
        test_reset_mid_pause();
        test_run_drop();
        test_dual_hit();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
